// File: rtl/sid_cmd_decoder.sv
// sid_cmd_decoder: turns an {address, data} byte stream into
// rate-limited register writes for one or more SID chips.
module sid_cmd_decoder #(
  parameter int NUM_SIDS     = 1,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 8,
  parameter int TIMEOUT_CYC  = 0,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic [7:0]                 in_tdata,
  input  logic                       in_tvalid,
  output logic                       in_tready,
  output logic [ADDR_W-1:0]          sid_addr,
  output logic [7:0]                 sid_data,
  output logic [NUM_SIDS-1:0]        sid_n_cs,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [7:0]                 err_cnt,
  output logic [7:0]                 ovf_cnt,
  output logic                       timeout_pulse
);

  localparam int CHIP_W = 8 - ADDR_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int ENT_W  = CHIP_W + ADDR_W + 8;
  localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TLIM   = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CHIP_W:0] NS_L = (CHIP_W + 1)'(NUM_SIDS);

  typedef enum logic {
    S_ADDR,
    S_DATA
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [CHIP_W-1:0]   chip_q;
  logic [ADDR_W-1:0]   reg_q;
  logic [TCNT_W-1:0]   tcnt;
  logic [TCNT_W-1:0]   tcnt_nx;

  logic [ENT_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;

  logic                full;
  logic                empty;
  logic                accept;
  logic                addr_ok;
  logic [CHIP_W-1:0]   addr_chip;
  logic                latch;
  logic                push;
  logic                pop;
  logic                drop;
  logic                rej;
  logic                tmo;

  logic [ENT_W-1:0]    head;
  logic [CHIP_W-1:0]   head_chip;
  logic [NUM_SIDS-1:0] cs_dec;

  assign full       = (level == LVL_W'(DEPTH));
  assign empty      = (level == '0);
  assign fifo_level = level;

  // ready depends only on registered state, never on the pop side
  assign in_tready = (DROP_ON_FULL != 0) || (state == S_ADDR) || !full;
  assign accept    = in_tvalid && in_tready;
  assign addr_chip = in_tdata[7:ADDR_W];
  assign addr_ok   = ({1'b0, addr_chip} < NS_L);
  assign pop       = clk_en && !empty;

  assign head      = mem[rd_ptr];
  assign head_chip = head[ENT_W-1 -: CHIP_W];

  // pair parser: next state, FIFO push, error and timeout events
  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    latch    = 1'b0;
    push     = 1'b0;
    drop     = 1'b0;
    rej      = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      S_ADDR: begin
        if (accept) begin
          if (addr_ok) begin
            latch    = 1'b1;
            tcnt_nx  = '0;
            state_nx = S_DATA;
          end else begin
            rej = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          state_nx = S_ADDR;
          if (full) drop = 1'b1;
          else      push = 1'b1;
        end else if (TIMEOUT_CYC != 0 &&
                     tcnt == TCNT_W'(TLIM)) begin
          tmo      = 1'b1;
          state_nx = S_ADDR;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
    endcase
  end

  // parser state, latched address and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_ADDR;
      tcnt          <= '0;
      chip_q        <= '0;
      reg_q         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      tcnt          <= tcnt_nx;
      timeout_pulse <= tmo;
      if (latch) begin
        chip_q <= addr_chip;
        reg_q  <= in_tdata[ADDR_W-1:0];
      end
    end
  end

  // FIFO storage; contents need no reset since level gates reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {chip_q, reg_q, in_tdata};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // one-hot active-low select for the head entry's chip
  always_comb begin
    cs_dec = '0;
    for (int i = 0; i < NUM_SIDS; i++) begin
      cs_dec[i] = (head_chip == CHIP_W'(i));
    end
  end

  // issue one write per clk_en period, holding it until the next
  always_ff @(posedge clk) begin
    if (rst) begin
      sid_addr <= '0;
      sid_data <= '0;
      sid_n_cs <= '1;
    end else if (clk_en) begin
      if (!empty) begin
        sid_addr <= head[8 +: ADDR_W];
        sid_data <= head[7:0];
        sid_n_cs <= ~cs_dec;
      end else begin
        sid_n_cs <= '1;
      end
    end
  end

  // saturating error and overflow counters
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (rej && err_cnt != 8'hFF)  err_cnt <= err_cnt + 1'b1;
      if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sid_cmd_decoder.sv
// tb_sid_cmd_decoder: four decoder configurations driven with
// directed pairs; a monitor checks every issued write in order.
module tb_sid_cmd_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  logic ce_on = 1'b0;
  logic upd = 1'b1;
  int   ce_cnt = 0;
  int   npass = 0;
  int   ntot = 0;
  int   tpc = 0;

  logic [7:0] td [4];
  logic       tv [4];
  logic       rdy [4];
  logic [4:0] sa [4];
  logic [7:0] sd [4];
  logic [7:0] ec [4];
  logic [7:0] oc [4];
  logic       tp [4];
  logic       cs_a, cs_c, cs_d;
  logic [1:0] cs_b;
  logic [3:0] lv_a, lv_b;
  logic [2:0] lv_c, lv_d;

  logic [14:0] expq [4][$];
  logic [14:0] last [4];

  always #5 clk = ~clk;

  sid_cmd_decoder #(.NUM_SIDS(1)) u_a (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .in_tdata(td[0]), .in_tvalid(tv[0]), .in_tready(rdy[0]),
    .sid_addr(sa[0]), .sid_data(sd[0]), .sid_n_cs(cs_a),
    .fifo_level(lv_a), .err_cnt(ec[0]), .ovf_cnt(oc[0]),
    .timeout_pulse(tp[0]));

  sid_cmd_decoder #(.NUM_SIDS(2), .TIMEOUT_CYC(100)) u_b (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .in_tdata(td[1]), .in_tvalid(tv[1]), .in_tready(rdy[1]),
    .sid_addr(sa[1]), .sid_data(sd[1]), .sid_n_cs(cs_b),
    .fifo_level(lv_b), .err_cnt(ec[1]), .ovf_cnt(oc[1]),
    .timeout_pulse(tp[1]));

  sid_cmd_decoder #(.DEPTH(4), .DROP_ON_FULL(0)) u_c (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .in_tdata(td[2]), .in_tvalid(tv[2]), .in_tready(rdy[2]),
    .sid_addr(sa[2]), .sid_data(sd[2]), .sid_n_cs(cs_c),
    .fifo_level(lv_c), .err_cnt(ec[2]), .ovf_cnt(oc[2]),
    .timeout_pulse(tp[2]));

  sid_cmd_decoder #(.DEPTH(4), .DROP_ON_FULL(1)) u_d (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .in_tdata(td[3]), .in_tvalid(tv[3]), .in_tready(rdy[3]),
    .sid_addr(sa[3]), .sid_data(sd[3]), .sid_n_cs(cs_d),
    .fifo_level(lv_d), .err_cnt(ec[3]), .ovf_cnt(oc[3]),
    .timeout_pulse(tp[3]));

  function automatic logic [1:0] csv(input int u);
    case (u)
      0:       return {1'b1, cs_a};
      1:       return cs_b;
      2:       return {1'b1, cs_c};
      default: return {1'b1, cs_d};
    endcase
  endfunction

  function automatic logic [3:0] lvl(input int u);
    case (u)
      0:       return lv_a;
      1:       return lv_b;
      2:       return {1'b0, lv_c};
      default: return {1'b0, lv_d};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic push_exp(input int u, input logic [1:0] cs,
                          input logic [4:0] a, input logic [7:0] d);
    expq[u].push_back({cs, a, d});
  endtask

  // clk_en strobe, every 4th cycle while enabled
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ce_cnt++;
      clk_en = ce_on && (ce_cnt % 4 == 0);
    end
  end

  // outputs may only change after a clk_en or reset edge
  always @(posedge clk) upd <= clk_en | rst;

  task automatic mon(input int u);
    logic [14:0] cur;
    logic [14:0] e;
    cur = {csv(u), sa[u], sd[u]};
    if (!upd) begin
      chk($sformatf("hold%0d", u), 32'(cur), 32'(last[u]));
    end else begin
      last[u] = cur;
      if (csv(u) != 2'b11) begin
        if (expq[u].size() == 0) begin
          chk($sformatf("unexpected_write%0d", u), 32'(cur), 32'h7fff);
        end else begin
          e = expq[u].pop_front();
          chk($sformatf("write%0d", u), 32'(cur), 32'(e));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 4; u++) mon(u);
    if (tp[1]) tpc++;
  end

  task automatic send(input int u, input logic [7:0] b);
    int n;
    @(negedge clk);
    td[u] = b;
    tv[u] = 1'b1;
    n = 0;
    while (!rdy[u] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[u]) chk($sformatf("send_timeout%0d", u), 0, 1);
    @(posedge clk);
    #1;
    tv[u] = 1'b0;
  endtask

  task automatic pair(input int u, input logic [7:0] a,
                      input logic [7:0] d);
    send(u, a);
    send(u, d);
  endtask

  task automatic wait_ce();
    int n;
    n = 0;
    @(negedge clk);
    while (!clk_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!clk_en) chk("wait_ce_timeout", 0, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      td[i] = 8'h00;
      tv[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      chk("rst_cs", 32'(csv(u)), 32'h3);
      chk("rst_lvl", 32'(lvl(u)), 0);
      chk("rst_addr", 32'(sa[u]), 0);
      chk("rst_data", 32'(sd[u]), 0);
      chk("rst_err", 32'(ec[u]), 0);
      chk("rst_ovf", 32'(oc[u]), 0);
      chk("rst_tp", 32'(tp[u]), 0);
      chk("rst_rdy", 32'(rdy[u]), 1);
    end
    rst = 1'b0;
    ce_on = 1'b1;

    // single chip: one write spanning exactly one clk_en period
    push_exp(0, 2'b10, 5'h18, 8'h0F);
    pair(0, 8'h18, 8'h0F);
    wait_ce();
    @(posedge clk);
    #1;
    chk("t1_cs_low", 32'(cs_a), 0);
    chk("t1_addr", 32'(sa[0]), 32'h18);
    chk("t1_data", 32'(sd[0]), 32'h0F);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_cs_held", 32'(cs_a), 0);
    @(posedge clk);
    #1;
    chk("t1_cs_release", 32'(cs_a), 1);

    // two chips, ordered writes
    push_exp(1, 2'b01, 5'h01, 8'h55);
    push_exp(1, 2'b10, 5'h01, 8'hAA);
    pair(1, 8'h21, 8'h55);
    pair(1, 8'h01, 8'hAA);

    // out-of-range chip rejected, parser stays in ADDR
    send(1, 8'h45);
    push_exp(1, 2'b10, 5'h02, 8'h11);
    pair(1, 8'h02, 8'h11);
    @(negedge clk);
    chk("t3_err", 32'(ec[1]), 1);
    repeat (30) @(posedge clk);
    chk("t3_drain", expq[1].size(), 0);

    // timeout resync after 100 idle cycles in DATA
    tpc = 0;
    send(1, 8'h04);
    repeat (100) @(posedge clk);
    push_exp(1, 2'b10, 5'h05, 8'h33);
    pair(1, 8'h05, 8'h33);
    repeat (30) @(posedge clk);
    chk("t4_pulses", tpc, 1);
    chk("t4_err", 32'(ec[1]), 1);
    chk("t4_drain", expq[1].size(), 0);

    // backpressure mode: burst of 6 with issue stalled
    ce_on = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 6; i++)
      push_exp(2, 2'b10, 5'(i), 8'(8'hA0 + i));
    for (int i = 0; i < 4; i++)
      pair(2, 8'(i), 8'(8'hA0 + i));
    send(2, 8'h04);
    @(negedge clk);
    td[2] = 8'hA4;
    tv[2] = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_stall_rdy", 32'(rdy[2]), 0);
    chk("t5_full_lvl", 32'(lv_c), 4);
    ce_on = 1'b1;
    n = 0;
    while (!rdy[2] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("t5_resume", 32'(rdy[2]), 1);
    @(posedge clk);
    #1;
    tv[2] = 1'b0;
    pair(2, 8'h05, 8'hA5);
    repeat (60) @(posedge clk);
    chk("t5_drain", expq[2].size(), 0);

    // drop mode: same burst, two writes lost
    ce_on = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++)
      push_exp(3, 2'b10, 5'(i), 8'(8'hB0 + i));
    for (int i = 0; i < 6; i++)
      pair(3, 8'(i), 8'(8'hB0 + i));
    @(negedge clk);
    chk("t5d_lvl", 32'(lv_d), 4);
    chk("t5d_ovf", 32'(oc[3]), 2);
    chk("t5d_rdy", 32'(rdy[3]), 1);
    ce_on = 1'b1;
    repeat (40) @(posedge clk);
    chk("t5d_drain", expq[3].size(), 0);
    chk("t5d_empty", 32'(lv_d), 0);

    // reset mid-pair with entries queued
    ce_on = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++)
      pair(0, 8'(i + 1), 8'(8'hC0 + i));
    send(0, 8'h07);
    @(negedge clk);
    chk("t6_lvl_pre", 32'(lv_a), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_lvl", 32'(lv_a), 0);
    chk("t6_cs", 32'(cs_a), 1);
    push_exp(0, 2'b10, 5'h09, 8'h3C);
    pair(0, 8'h09, 8'h3C);
    ce_on = 1'b1;
    repeat (40) @(posedge clk);
    for (int u = 0; u < 4; u++)
      chk("final_drain", expq[u].size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
